// File: rtl/cam_capture.sv
// Camera pixel-interface receiver: synchronises pclk/href/vsync/data into clk and emits RGB565 pixels with x/y.
// Optional CAM_CAPTURE_RGB332_EN: pix_data carries the truncated RGB332 form of each pixel instead.
module cam_capture #(
   parameter int H_PIXELS    = 640,
   parameter int V_LINES     = 480,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        clr_err,
   input  logic        cam_pclk,
   input  logic        cam_href,
   input  logic        cam_vsync,
   input  logic [7:0]  cam_data,
   input  logic        fifo_full,
   output logic        pix_wr,
   output logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        frame_start,
   output logic        frame_done,
   output logic        overflow,
   output logic        line_err
);

   localparam int CW = 11;
   localparam logic [9:0] H_MAX = 10'(H_PIXELS);
   localparam logic [8:0] V_MAX = 9'(V_LINES);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, BYTE_LO, BYTE_HI} state_t;

   logic [SYNC_STAGES*CW-1:0] sync_q;
   logic [CW-1:0] sync_last;
   logic [CW-1:0] cam_q;
   logic          pclk_prev_q, href_prev_q, vs_prev_q;
   logic          rise_q, href_fall_q, vs_rise_q, vs_fall_q, href_lvl_q;
   logic [7:0]    byte_q;

   state_t        state_q;
   logic [7:0]    byte0_q;
   logic [9:0]    x_q;
   logic [8:0]    y_q, y_d;
   logic [15:0]   word, pix_fmt;
   logic          pix_wr_q, frame_start_q, frame_done_q, overflow_q, line_err_q;
   logic [15:0]   pix_data_q;
   logic [9:0]    pix_x_q;
   logic [8:0]    pix_y_q;

   assign sync_last = sync_q[SYNC_STAGES*CW-1 -: CW];

   // All four camera inputs share one chain so href/vsync/data stay aligned with pclk
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         cam_q       <= '0;
         pclk_prev_q <= 1'b0;
         href_prev_q <= 1'b0;
         vs_prev_q   <= 1'b0;
         rise_q      <= 1'b0;
         href_fall_q <= 1'b0;
         vs_rise_q   <= 1'b0;
         vs_fall_q   <= 1'b0;
         href_lvl_q  <= 1'b0;
         byte_q      <= '0;
      end else begin
         sync_q      <= {sync_q[(SYNC_STAGES-1)*CW-1:0], cam_vsync, cam_href, cam_pclk, cam_data};
         cam_q       <= sync_last;
         pclk_prev_q <= cam_q[8];
         href_prev_q <= cam_q[9];
         vs_prev_q   <= cam_q[10];
         rise_q      <= cam_q[8] & ~pclk_prev_q;
         href_fall_q <= ~cam_q[9] & href_prev_q;
         vs_rise_q   <= cam_q[10] & ~vs_prev_q;
         vs_fall_q   <= ~cam_q[10] & vs_prev_q;
         href_lvl_q  <= cam_q[9];
         byte_q      <= cam_q[7:0];
      end
   end

   assign word = {byte0_q, byte_q};
`ifdef CAM_CAPTURE_RGB332_EN
   assign pix_fmt = {8'h00, word[15:13], word[10:8], word[4:3]};
`else
   assign pix_fmt = word;
`endif

   always_comb begin
      y_d = y_q;
      if (y_q < V_MAX) y_d = y_q + 9'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         byte0_q       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         pix_wr_q      <= 1'b0;
         pix_data_q    <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         overflow_q    <= 1'b0;
         line_err_q    <= 1'b0;
      end else begin
         pix_wr_q      <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         // Error sets below come later in the block, so they win over a same-cycle clear
         if (clr_err) begin
            overflow_q <= 1'b0;
            line_err_q <= 1'b0;
         end
         if (state_q == IDLE) begin
            if (vs_fall_q && enable) begin
               state_q       <= WAIT_LINE;
               frame_start_q <= 1'b1;
               y_q           <= '0;
            end
         end else if (vs_rise_q) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
            if (href_lvl_q) line_err_q <= 1'b1;
         end else begin
            case (state_q)
               WAIT_LINE: begin
                  if (rise_q && href_lvl_q) begin
                     byte0_q <= byte_q;
                     x_q     <= '0;
                     state_q <= BYTE_LO;
                  end
               end
               BYTE_LO: begin
                  if (href_fall_q) begin
                     line_err_q <= 1'b1;
                     y_q        <= y_d;
                     state_q    <= WAIT_LINE;
                  end else if (rise_q && href_lvl_q) begin
                     state_q <= BYTE_HI;
                     if (x_q >= H_MAX) begin
                        line_err_q <= 1'b1;
                     end else begin
                        x_q <= x_q + 10'd1;
                        if (y_q < V_MAX) begin
                           if (fifo_full) begin
                              overflow_q <= 1'b1;
                           end else begin
                              pix_wr_q   <= 1'b1;
                              pix_data_q <= pix_fmt;
                              pix_x_q    <= x_q;
                              pix_y_q    <= y_q;
                           end
                        end
                     end
                  end
               end
               BYTE_HI: begin
                  if (href_fall_q) begin
                     y_q     <= y_d;
                     state_q <= WAIT_LINE;
                  end else if (rise_q && href_lvl_q) begin
                     byte0_q <= byte_q;
                     state_q <= BYTE_LO;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign pix_wr      = pix_wr_q;
   assign pix_data    = pix_data_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign overflow    = overflow_q;
   assign line_err    = line_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: camera byte stream in, scoreboard of expected pixel writes out.
module tb_cam_capture;
   localparam int H = 4;
   localparam int V = 6;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        clr_err = 1'b0;
   logic        cam_pclk = 1'b0;
   logic        cam_href = 1'b0;
   logic        cam_vsync = 1'b1;
   logic [7:0]  cam_data = 8'h00;
   logic        fifo_full = 1'b0;
   logic        pix_wr;
   logic [15:0] pix_data;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        frame_start, frame_done, overflow, line_err;

   int checks = 0;
   int failures = 0;
   logic [34:0] exp_q[$];
   logic [34:0] obs[$];
   int rd_idx = 0;
   int fs_cnt = 0;
   int fd_cnt = 0;

   cam_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
      .cam_pclk(cam_pclk), .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
      .fifo_full(fifo_full), .pix_wr(pix_wr), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .frame_done(frame_done), .overflow(overflow), .line_err(line_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pix_wr === 1'b1) obs.push_back({pix_data, pix_x, pix_y});
      if (frame_start === 1'b1) fs_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
   end

   function automatic logic [15:0] fmt(input logic [15:0] w);
`ifdef CAM_CAPTURE_RGB332_EN
      return {8'h00, w[15:13], w[10:8], w[4:3]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic expect_px(input logic [15:0] w, input int x, input int y);
      exp_q.push_back({fmt(w), 10'(x), 9'(y)});
   endtask

   task automatic send_byte(input logic [7:0] b, input bit lat);
      @(posedge clk); #2;
      cam_data = b;
      cam_href = 1'b1;
      repeat (3) @(posedge clk);
      #2 cam_pclk = 1'b1;
      if (lat) begin
         repeat (S + 2) @(posedge clk);
         #1 chk("latency_early", 64'(pix_wr), 64'(0));
         @(posedge clk);
         #1 chk("latency_edge", 64'(pix_wr), 64'(1));
      end else begin
         repeat (4) @(posedge clk);
      end
      #2 cam_pclk = 1'b0;
   endtask

   task automatic send_px(input logic [15:0] w);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
   endtask

   task automatic end_line();
      @(posedge clk); #2 cam_href = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   task automatic set_vsync(input logic v);
      @(posedge clk); #2 cam_vsync = v;
      repeat (8) @(posedge clk);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #2 clr_err = 1'b1;
      @(posedge clk); #2 clr_err = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      int want;
      logic [34:0] e;
      n = 0;
      want = rd_idx + exp_q.size();
      while (obs.size() < want && n < 200) begin
         @(posedge clk);
         n++;
      end
      repeat (12) @(posedge clk);
      chk({tag, "_nwr"}, 64'(obs.size() - rd_idx), 64'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < obs.size()) chk({tag, "_pix"}, 64'(obs[rd_idx]), 64'(e));
         rd_idx++;
      end
      rd_idx = obs.size();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with camera lines toggling
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         cam_pclk  = ~cam_pclk;
         cam_href  = ~cam_href;
         cam_vsync = ~cam_vsync;
         cam_data  = 8'($urandom);
         chk("reset_outputs", 64'({pix_wr, pix_data, pix_x, pix_y, frame_start, frame_done, overflow, line_err}), 64'(0));
      end
      cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; cam_data = 8'h00;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (10) @(posedge clk);
      chk("reset_no_writes", 64'(obs.size()), 64'(0));
      chk("reset_no_fs", 64'(fs_cnt), 64'(0));

      // one line of four pixels, with pix_wr latency measured on the first pixel
      enable = 1'b1;
      set_vsync(1'b0);
      chk("frame_start_once", 64'(fs_cnt), 64'(1));
      expect_px(16'h1234, 0, 0);
      expect_px(16'h5678, 1, 0);
      expect_px(16'h9ABC, 2, 0);
      expect_px(16'hDEF0, 3, 0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b1);
      send_px(16'h5678);
      send_px(16'h9ABC);
      send_px(16'hDEF0);
      end_line();
      drain("line0");
      chk("line0_overflow", 64'(overflow), 64'(0));
      chk("line0_line_err", 64'(line_err), 64'(0));

      // fifo_full during the second pixel: dropped, x still advances
      expect_px(16'h1122, 0, 1);
      expect_px(16'h5566, 2, 1);
      expect_px(16'h7788, 3, 1);
      send_px(16'h1122);
      send_byte(8'h33, 1'b0);
      fifo_full = 1'b1;
      send_byte(8'h44, 1'b0);
      send_byte(8'h55, 1'b0);
      fifo_full = 1'b0;
      send_byte(8'h66, 1'b0);
      send_px(16'h7788);
      end_line();
      drain("full");
      chk("overflow_set", 64'(overflow), 64'(1));
      chk("full_no_line_err", 64'(line_err), 64'(0));
      pulse_clr();
      chk("overflow_cleared", 64'(overflow), 64'(0));

      // odd byte count, then a clean line restarting at x=0
      expect_px(16'hA1A2, 0, 2);
      send_px(16'hA1A2);
      send_byte(8'hA3, 1'b0);
      end_line();
      drain("odd");
      chk("odd_line_err", 64'(line_err), 64'(1));
      expect_px(16'hB1B2, 0, 3);
      send_px(16'hB1B2);
      end_line();
      drain("after_odd");
      chk("line_err_sticky", 64'(line_err), 64'(1));
      pulse_clr();
      chk("line_err_cleared", 64'(line_err), 64'(0));

      // vsync rises mid-line
      expect_px(16'hC1C2, 0, 4);
      send_px(16'hC1C2);
      send_byte(8'hC3, 1'b0);
      set_vsync(1'b1);
      end_line();
      drain("vs_mid");
      chk("vs_mid_frame_done", 64'(fd_cnt), 64'(1));
      chk("vs_mid_line_err", 64'(line_err), 64'(1));

      // capture disabled: a whole frame passes with no writes or pulses
      enable = 1'b0;
      pulse_clr();
      set_vsync(1'b0);
      send_px(16'hD1D2);
      send_px(16'hD3D4);
      end_line();
      set_vsync(1'b1);
      drain("disabled");
      chk("disabled_fs", 64'(fs_cnt), 64'(1));
      chk("disabled_fd", 64'(fd_cnt), 64'(1));
      chk("disabled_line_err", 64'(line_err), 64'(0));

      // new frame; enable dropped after start must not abort it
      enable = 1'b1;
      set_vsync(1'b0);
      chk("frame2_start", 64'(fs_cnt), 64'(2));
      enable = 1'b0;
      expect_px(16'hF81F, 0, 0);
      expect_px(16'h0102, 1, 0);
      expect_px(16'h0304, 2, 0);
      expect_px(16'h0506, 3, 0);
      send_px(16'hF81F);
      send_px(16'h0102);
      send_px(16'h0304);
      send_px(16'h0506);
      send_px(16'h0708);
      end_line();
      drain("wide");
      chk("wide_line_err", 64'(line_err), 64'(1));
      pulse_clr();
      for (int y = 1; y <= V; y++) begin
         if (y < V) expect_px({8'(y), 8'h5A}, 0, y);
         send_px({8'(y), 8'h5A});
         end_line();
      end
      drain("tall");
      chk("tall_no_line_err", 64'(line_err), 64'(0));
      set_vsync(1'b1);
      chk("frame2_done", 64'(fd_cnt), 64'(2));
      chk("frame2_fs_total", 64'(fs_cnt), 64'(2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
